// File: rtl/tx_req_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_req_sched_if
//  Description : Channel-side and multiplexer-side signal bundle of the
//                tx_req_sched scheduler.
//                  src_valid[3:0]    per-channel word offer
//                  src_data_0..3     16-bit channel words
//                  src_ready[3:0]    per-channel holding register free
//                  req[3:0]          one-hot request-to-send
//                  out_0..3          held channel words to the multiplexer
//                  accept[3:0]       multiplexer accept
//                master : the surrounding logic (sources + multiplexer)
//                slave  : the scheduler itself
//  Revision    : 1.0  initial release
// ============================================================================
interface tx_req_sched_if;
    logic [3:0]  src_valid;
    logic [15:0] src_data_0;
    logic [15:0] src_data_1;
    logic [15:0] src_data_2;
    logic [15:0] src_data_3;
    logic [3:0]  src_ready;
    logic [3:0]  req;
    logic [15:0] out_0;
    logic [15:0] out_1;
    logic [15:0] out_2;
    logic [15:0] out_3;
    logic [3:0]  accept;

    modport master (
        output src_valid, src_data_0, src_data_1, src_data_2, src_data_3, accept,
        input  src_ready, req, out_0, out_1, out_2, out_3
    );

    modport slave (
        input  src_valid, src_data_0, src_data_1, src_data_2, src_data_3, accept,
        output src_ready, req, out_0, out_1, out_2, out_3
    );
endinterface
`default_nettype wire

// File: rtl/tx_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tx_req_sched
//  Description : Four-channel transmit request scheduler. Each channel owns
//                one 16-bit holding register and a pending flag. A
//                round-robin IDLE/REQ/REL handshake FSM presents one held
//                word at a time to the tx multiplexer.
//  Ports       : clk          single clock, rising edge
//                rst          asynchronous active-high reset
//                bus          tx_req_sched_if.slave (channel + mux signals)
//                busy         high whenever the FSM is not IDLE
//                timeout_err  one-cycle pulse when the watchdog drops a word
//  Parameters  : TIMEOUT_CYCLES  cycles allowed in REQ (2..65535)
//  Options     : TX_REQ_SCHED_TIMEOUT_EN  enables the REQ watchdog; when
//                undefined REQ waits indefinitely and timeout_err is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_req_sched #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    tx_req_sched_if.slave bus,
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_pending;
    logic [15:0] r_hold [4];
    logic [3:0]  r_req;
    logic [3:0]  w_req_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  w_rr_nxt;
    logic        w_release;
    logic [3:0]  w_clr_mask;
    logic [3:0]  w_load;
    logic        w_found;
    logic [1:0]  w_search;
    logic        w_timeout;
    logic [15:0] w_src_data [4];

    assign w_src_data[0] = bus.src_data_0;
    assign w_src_data[1] = bus.src_data_1;
    assign w_src_data[2] = bus.src_data_2;
    assign w_src_data[3] = bus.src_data_3;

    // A channel can only load while its register is free, so a word under
    // transfer never changes and the clearing edge can never reload it.
    assign w_load     = bus.src_valid & ~r_pending;
    assign w_clr_mask = w_release ? (4'b0001 << r_grant) : 4'b0000;

    // ------------------------------------------------------------------------
    // Holding registers and pending flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= 16'h0000;
            end
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_load;
            for (int i = 0; i < 4; i++) begin
                if (w_load[i]) begin
                    r_hold[i] <= w_src_data[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin search: first pending channel at or above rr_ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [1:0] idx;
        w_found  = 1'b0;
        w_search = r_rr_ptr;
        idx      = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = r_rr_ptr + 2'(k);
            if (r_pending[idx]) begin
                w_found  = 1'b1;
                w_search = idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_req    <= 4'h0;
            r_grant  <= 2'd0;
            r_rr_ptr <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and registered-output next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_REQ;
                    w_grant_nxt = w_search;
                    w_req_nxt   = 4'b0001 << w_search;
                end
            end
            ST_REQ: begin
                if (bus.accept[r_grant]) begin
                    w_state_nxt = ST_REL;
                    w_req_nxt   = 4'h0;
                end else if (w_timeout) begin
                    // Watchdog drop: discard the word and move on as if released.
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 4'h0;
                    w_release   = 1'b1;
                    w_rr_nxt    = r_grant + 2'd1;
                end
            end
            ST_REL: begin
                if (!bus.accept[r_grant]) begin
                    w_state_nxt = ST_IDLE;
                    w_release   = 1'b1;
                    w_rr_nxt    = r_grant + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 4'h0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // REQ watchdog
    // ------------------------------------------------------------------------
`ifdef TX_REQ_SCHED_TIMEOUT_EN
    // The counter is zero on the first REQ cycle; the drop happens on the
    // edge where it would reach TIMEOUT_CYCLES-1, so req stays high for
    // TIMEOUT_CYCLES-1 cycles.
    localparam logic [15:0] C_DROP_CNT = 16'(TIMEOUT_CYCLES - 2);

    logic [15:0] r_to_cnt;
    logic        r_timeout_err;
    logic        w_drop;

    assign w_timeout = (r_to_cnt == C_DROP_CNT);
    assign w_drop    = (r_state == ST_REQ) && !bus.accept[r_grant] && w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt      <= 16'h0000;
            r_timeout_err <= 1'b0;
        end else begin
            r_to_cnt      <= (r_state == ST_REQ) ? r_to_cnt + 16'd1 : 16'h0000;
            r_timeout_err <= w_drop;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy          = (r_state != ST_IDLE);
    assign bus.src_ready = ~r_pending;
    assign bus.req       = r_req;
    assign bus.out_0     = r_hold[0];
    assign bus.out_1     = r_hold[1];
    assign bus.out_2     = r_hold[2];
    assign bus.out_3     = r_hold[3];

endmodule
`default_nettype wire

// File: tb/tb_tx_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_req_sched
//  Description : Self-checking bench for tx_req_sched. Stimulus pushes the
//                expected grant order (derived from round-robin rules) and
//                the loaded words into queues; a monitor pops them whenever
//                a new request appears. A multiplexer model answers requests
//                with random delays and noise on non-granted accept bits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tx_req_sched;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic timeout_err;

    tx_req_sched_if bus ();

    tx_req_sched #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          exp_gnt [$];
    logic [15:0] model_data [4][$];
    int          model_rr = 0;
    int          req_pulses = 0;
    int          to_pulses = 0;
    bit          mux_en = 1'b0;
    int          hold_min = 1;
    int          hold_max = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] out_of(input int ch);
        case (ch)
            0:       return bus.out_0;
            1:       return bus.out_1;
            2:       return bus.out_2;
            default: return bus.out_3;
        endcase
    endfunction

    // Reference: a batch loaded while idle drains in round-robin order
    // starting at the model pointer; the pointer ends one past the last grant.
    task automatic push_batch(input logic [3:0] mask);
        int last = model_rr;
        for (int k = 0; k < 4; k++) begin
            int ch = (model_rr + k) % 4;
            if (mask[ch]) begin
                exp_gnt.push_back(ch);
                last = ch;
            end
        end
        model_rr = (last + 1) % 4;
    endtask

    // Called at a negedge; presents the words for one clock.
    task automatic load(input logic [3:0] mask, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3);
        check("load_ready", bus.src_ready & mask, mask);
        bus.src_data_0 = d0;
        bus.src_data_1 = d1;
        bus.src_data_2 = d2;
        bus.src_data_3 = d3;
        bus.src_valid  = mask;
        if (mask[0]) model_data[0].push_back(d0);
        if (mask[1]) model_data[1].push_back(d1);
        if (mask[2]) model_data[2].push_back(d2);
        if (mask[3]) model_data[3].push_back(d3);
        @(negedge clk);
        bus.src_valid = 4'h0;
    endtask

    task automatic wait_drain(input int max, input string name);
        int n = 0;
        while (!(busy == 1'b0 && bus.src_ready == 4'hF && exp_gnt.size() == 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < max), 32'd1);
    endtask

    task automatic wait_req(input logic [3:0] mask, input int max, input string name);
        int n = 0;
        while ((bus.req & mask) == 4'h0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, 32'(n < max), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Multiplexer model
    // ------------------------------------------------------------------------
    initial begin : mux_model
        logic [3:0] g_oh;
        bus.accept = 4'h0;
        forever begin
            @(negedge clk);
            if (mux_en && !rst && bus.req != 4'h0) begin
                g_oh = bus.req;
                repeat ($urandom_range(3, 0)) begin
                    bus.accept = 4'($urandom) & ~g_oh;
                    @(negedge clk);
                end
                bus.accept = g_oh | (4'($urandom) & ~g_oh);
                repeat ($urandom_range(hold_max, hold_min)) @(negedge clk);
                bus.accept = 4'h0;
            end else begin
                bus.accept = 4'h0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin : monitor
        logic [3:0]  prev_req = 4'h0;
        bit          active = 1'b0;
        int          g = 0;
        logic [15:0] held = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 4'h0;
                active   = 1'b0;
            end else begin
                check("req_onehot0", 32'($onehot0(bus.req)), 32'd1);
                if (timeout_err) to_pulses++;
`ifndef TX_REQ_SCHED_TIMEOUT_EN
                check("timeout_err_zero", 32'(timeout_err), 32'd0);
`endif
                if (active) begin
                    if (bus.src_ready[g]) active = 1'b0;
                    else check("out_stable", 32'(out_of(g)), 32'(held));
                end
                if (prev_req == 4'h0 && bus.req != 4'h0) begin
                    req_pulses++;
                    if (exp_gnt.size() == 0) begin
                        check("unexpected_req", 32'(bus.req), 32'd0);
                    end else begin
                        g = exp_gnt.pop_front();
                        check("grant", 32'(bus.req), 32'(4'b0001 << g));
                        held = 16'h0;
                        if (model_data[g].size() > 0) held = model_data[g].pop_front();
                        check("grant_data", 32'(out_of(g)), 32'(held));
                        check("ready_low", 32'(bus.src_ready[g]), 32'd0);
                        check("busy_in_req", 32'(busy), 32'd1);
                        active = 1'b1;
                    end
                end
                prev_req = bus.req;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : stim
        int pulses0;
        int n;
        int bad;
        int n0;
        int n3;
        int cyc;
        int first;
        logic [3:0]  m;
        logic [3:0]  v;

        rst            = 1'b1;
        bus.src_valid  = 4'h0;
        bus.src_data_0 = 16'h0;
        bus.src_data_1 = 16'h0;
        bus.src_data_2 = 16'h0;
        bus.src_data_3 = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(bus.req), 32'h0);
        check("rst_ready", 32'(bus.src_ready), 32'hF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        check("rst_out", {bus.out_0, bus.out_1} | {bus.out_2, bus.out_3}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // All four channels in one cycle, multiplexer accepting.
        mux_en  = 1'b1;
        pulses0 = req_pulses;
        push_batch(4'hF);
        load(4'hF, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        wait_drain(200, "all4");
        check("all4_pulses", 32'(req_pulses - pulses0), 32'd4);

        // Single channel latency with the multiplexer idle.
        mux_en = 1'b0;
        push_batch(4'b0100);
        load(4'b0100, 16'h0, 16'h0, 16'hBEEF, 16'h0);
        check("lat_req_t1", 32'(bus.req), 32'h0);
        check("lat_ready", 32'(bus.src_ready), 32'hB);
        check("lat_out2", 32'(bus.out_2), 32'hBEEF);
        @(negedge clk);
        check("lat_req_t2", 32'(bus.req), 32'b0100);
        repeat (5) @(negedge clk);
        check("hold_req", 32'(bus.req), 32'b0100);
        check("hold_ready", 32'(bus.src_ready), 32'hB);
        mux_en = 1'b1;
        wait_drain(100, "beef");

        // Alternation: ch3 granted, then ch0 and ch3 kept refilled.
        push_batch(4'b1000);
        load(4'b1000, 16'h0, 16'h0, 16'h0, 16'h3C00);
        wait_req(4'b1000, 20, "alt_first");
        for (int i = 0; i < 6; i++) begin
            exp_gnt.push_back(0);
            exp_gnt.push_back(3);
        end
        model_rr = 0;
        n0  = 0;
        n3  = 0;
        cyc = 0;
        while ((n0 < 6 || n3 < 6) && cyc < 2000) begin
            v = 4'h0;
            if (n0 < 6 && bus.src_ready[0]) begin
                v[0] = 1'b1;
                bus.src_data_0 = 16'h0A00 + 16'(n0);
                model_data[0].push_back(16'h0A00 + 16'(n0));
                n0++;
            end
            if (n3 < 6 && bus.src_ready[3]) begin
                v[3] = 1'b1;
                bus.src_data_3 = 16'h3C01 + 16'(n3);
                model_data[3].push_back(16'h3C01 + 16'(n3));
                n3++;
            end
            bus.src_valid = v;
            @(negedge clk);
            cyc++;
        end
        bus.src_valid = 4'h0;
        check("alt_refills_done", 32'(cyc < 2000), 32'd1);
        wait_drain(300, "alt");

        // Random batches with random hold lengths.
        for (int it = 0; it < 24; it++) begin
            m        = 4'($urandom_range(15, 1));
            hold_max = $urandom_range(4, 1);
            push_batch(m);
            load(m, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            wait_drain(200, "rand");
        end

        // Reset during REL of a ch1 transfer.
        hold_min = 8;
        hold_max = 8;
        push_batch(4'b0010);
        load(4'b0010, 16'h0, 16'h5A5A, 16'h0, 16'h0);
        wait_req(4'b0010, 20, "rel_rst");
        n = 0;
        while (bus.req != 4'h0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rel_reached", 32'(n < 20), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(bus.req), 32'h0);
        check("arst_ready", 32'(bus.src_ready), 32'hF);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_out1", 32'(bus.out_1), 32'h0);
        exp_gnt.delete();
        for (int c = 0; c < 4; c++) model_data[c].delete();
        model_rr = 0;
        hold_min = 1;
        hold_max = 3;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.req != 4'h0 || busy) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);
        push_batch(4'b1001);
        load(4'b1001, 16'hC0DE, 16'h0, 16'h0, 16'hF00D);
        wait_drain(200, "post_rst");

`ifdef TX_REQ_SCHED_TIMEOUT_EN
        // Watchdog: accept held low, both words dropped in turn.
        mux_en = 1'b0;
        first  = model_rr % 4;
        while (!(first == 1 || first == 2)) first = (first + 1) % 4;
        push_batch(4'b0110);
        load(4'b0110, 16'h0, 16'h1234, 16'h5678, 16'h0);
        wait_req(4'b0110, 20, "to");
        n = 0;
        while (bus.req != 4'h0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_req_cycles", 32'(n), 32'(TO - 1));
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_ready", 32'(bus.src_ready), 32'(4'hF & ~(4'b0110 & ~(4'b0001 << first))));
        @(negedge clk);
        check("to_pulse_end", 32'(timeout_err), 32'd0);
        check("to_next_grant", 32'(bus.req), 32'(4'b0110 & ~(4'b0001 << first)));
        wait_drain(100, "to");
        check("to_pulses", 32'(to_pulses), 32'd2);
        mux_en = 1'b1;
`else
        // No watchdog: a request waits indefinitely.
        mux_en = 1'b0;
        push_batch(4'b0001);
        load(4'b0001, 16'h7E57, 16'h0, 16'h0, 16'h0);
        wait_req(4'b0001, 20, "nto");
        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            if (bus.req != 4'b0001 || timeout_err !== 1'b0) bad++;
        end
        check("nto_req_held", 32'(bad), 32'd0);
        mux_en = 1'b1;
        wait_drain(100, "nto");
        check("nto_no_pulses", 32'(to_pulses), 32'd0);
`endif

        check("exp_queue_empty", 32'(exp_gnt.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_req_sched.md
TX_REQ_SCHED -- requirements
Module: tx_req_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 1024, cycles allowed in REQ before the watchdog drops the word (range 2..65535).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 src_valid  input  4  per-channel word offer, bit i = channel i.
REQ-005 src_data_0..src_data_3  input  16 each  channel words.
REQ-006 src_ready  output  4  per-channel buffer free; src_ready[i] = ~pending[i].
REQ-007 req  output  4  request-to-send to the tx multiplexer, registered, at most one bit high.
REQ-008 out_0..out_3  output  16 each  held channel words to the multiplexer, driven from the holding registers.
REQ-009 accept  input  4  multiplexer accept, high while the word is taken, low when done.
REQ-010 busy  output  1  high when state is not IDLE.
REQ-011 timeout_err  output  1  one-cycle pulse on a watchdog drop.

Function
REQ-012 Each channel SHALL have one 16-bit holding register and a pending flag; a word is loaded when src_valid[i] & src_ready[i] at a posedge, which sets pending[i].
REQ-013 A holding register SHALL NOT change while pending[i] is set, so out_i stays stable for the whole transfer.
REQ-014 The FSM SHALL have three states: IDLE, REQ, REL.
REQ-015 IDLE -> REQ when any pending bit is set; grant g SHALL be the first pending channel searched from rr_ptr upward with wrap 3->0; req[g] SHALL be 1 from the next cycle.
REQ-016 REQ -> REL when accept[g]=1 is sampled; req SHALL be 4'h0 in REL.
REQ-017 REL -> IDLE when accept[g]=0 is sampled; on that edge pending[g] SHALL clear and rr_ptr SHALL become g+1 mod 4.
REQ-018 Latency: a word loaded at edge t SHALL give req high after edge t+1 if the FSM is IDLE, i.e. 2 cycles from load.
REQ-019 src_ready[g] SHALL rise the cycle after the REL->IDLE edge; a load on that channel is not possible on the clearing edge.
REQ-020 Loads on non-granted channels SHALL proceed in every state, including simultaneous loads on all four channels.
REQ-021 With all four channels pending continuously, grants SHALL rotate 0,1,2,3,0 regardless of the multiplexer's fixed priority.
REQ-022 accept bits other than accept[g] SHALL be ignored.

Reset
REQ-023 rst SHALL immediately force state IDLE, pending 4'h0, holding registers 16'h0000, req 4'h0, rr_ptr 0, busy 0 and timeout_err 0; src_ready then reads 4'hF.
REQ-024 Reset mid-transfer SHALL discard all pending words without an accept or error indication.

Configuration
REQ-025 With macro TX_REQ_SCHED_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-026 If TIMEOUT_CYCLES-1 is reached without accept[g], the FSM SHALL go to IDLE, clear pending[g], advance rr_ptr to g+1, and pulse timeout_err for 1 cycle.
REQ-027 Without TX_REQ_SCHED_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be constant 0, and REQ SHALL wait indefinitely.

Verification
REQ-028 Load ch2=16'hBEEF with the multiplexer model idle -> req=4'b0100 two cycles after load; out_2=16'hBEEF is stable until REL exits; src_ready[2] is low until then.
REQ-029 Load all channels in one cycle (16'h1111..16'h4444) with the model accepting -> grant order 0,1,2,3 and exactly 4 req pulses, each one-hot.
REQ-030 After a ch3 grant, keep ch0 and ch3 continuously refilled -> next grant is ch0, then ch3, alternating.
REQ-031 Assert rst during REL of a ch1 transfer -> req=0, pending=0, src_ready=4'hF asynchronously; no further req until a new load.
REQ-032 Macro defined, TIMEOUT_CYCLES=8, accept held 0 -> after 7 REQ cycles timeout_err pulses once, pending[g] clears, and the next channel is granted.
REQ-033 Macro undefined, accept held 0 for 5000 cycles -> req stays high, timeout_err stays 0.
